sht30_target: RTL and testbench
===============================

SHT30_TARGET -- requirements
Module: sht30_target

Interface
REQ-001 SHALL have parameter ADDR7, default 7'h44, 7-bit I2C target address answered by the block.
REQ-002 SHALL have port clk_50M  input  1  system clock, 50 MHz.
REQ-003 SHALL have port rstn  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-004 SHALL have port scl_in  input  1  raw I2C SCL level from the pad.
REQ-005 SHALL have port sda_in  input  1  raw I2C SDA level from the pad.
REQ-006 SHALL have port sda_oe  output  1  1 = pull SDA low (open-drain); 0 = release.
REQ-007 SHALL have port temp_raw  input  16  temperature code to report.
REQ-008 SHALL have port humi_raw  input  16  humidity code to report.
REQ-009 SHALL have port cmd_valid  output  1  one-cycle pulse when a 2-byte command is received.
REQ-010 SHALL have port cmd_word  output  16  last received command, MSB first.
REQ-011 SHALL have port busy  output  1  high from an address match until STOP.

Function
REQ-012 SHALL pass scl_in/sda_in through 2-flop synchronisers and detect edges on the synchronised copies; START = SDA fall while SCL high; STOP = SDA rise while SCL high; each detected within 3 clk_50M cycles of the pad event.
REQ-013 SHALL use FSM states IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, WAIT_STOP.
REQ-014 SHALL enter ADDR on START from any state (repeated START included) and IDLE on STOP from any state, with sda_oe=0 in the same cycle STOP is detected.
REQ-015 SHALL sample SDA on each SCL rising edge, MSB first, 8 bits per byte.
REQ-016 SHALL change sda_oe only in the cycle after a detected SCL falling edge.
REQ-017 On address match with R/W=0, SHALL ACK in ADDR_ACK, then go to WR_BYTE.
REQ-018 On address match with R/W=1, SHALL ACK only if a measurement is pending, then go to RD_BYTE; otherwise SHALL NACK and go to WAIT_STOP.
REQ-019 On address mismatch, SHALL NACK (sda_oe=0) and go to WAIT_STOP; busy stays 0.
REQ-020 SHALL ACK write bytes 1 and 2 and NACK byte 3 onward, moving to WAIT_STOP after the first NACK.
REQ-021 After the byte-2 ACK, SHALL update cmd_word and pulse cmd_valid for one cycle.
REQ-022 If cmd_word==16'h2C06, SHALL snapshot temp_raw/humi_raw into internal registers and set pending.
REQ-023 SHALL clear pending when a read address is ACKed.
REQ-024 Read bytes in order SHALL be T[15:8], T[7:0], CRC(T), H[15:8], H[7:0], CRC(H); byte 7 onward SHALL be 8'hFF.
REQ-025 CRC SHALL be CRC-8, polynomial 0x31, init 0xFF, no reflection, no final XOR, taken over the 2 snapshot bytes.
REQ-026 In RD_ACK, SHALL release SDA and sample the master ACK; ACK -> next byte; NACK -> WAIT_STOP.
REQ-027 SHALL never drive SCL (no clock stretching).

Reset
REQ-028 While rstn=0: sda_oe=0, cmd_valid=0, cmd_word=16'h0000, busy=0, pending=0, snapshots=0, FSM=IDLE, synchronisers=1 (bus idle).
REQ-029 Reset deasserted mid-transfer SHALL leave the block in IDLE, ignoring the bus until the next START.

Structure
REQ-030 State encoding, the 16'h2C06 command constant, the CRC polynomial/init and the read byte count (6) SHALL live in shared package sht30_pkg.
REQ-031 CRC SHALL be a combinational sub-module crc8_sht30 (16-bit in, 8-bit out), instantiated twice.

Verification
REQ-032 Write 88 2C 06 with temp_raw=16'hBEEF, humi_raw=16'h8000 -> three ACKs; cmd_valid pulse with cmd_word=16'h2C06; pending=1.
REQ-033 Then repeated START, 89, read 6 bytes, NACK the last -> master sees BE EF 92 80 00 A2; FSM=WAIT_STOP; pending=0.
REQ-034 Address 90 (write) -> NACK, sda_oe=0 throughout, busy=0, FSM=IDLE after STOP.
REQ-035 Read 89 with no pending measurement -> NACK on the address byte; no data bytes driven.
REQ-036 Write 88 30 A2 -> cmd_valid with cmd_word=16'h30A2, no snapshot; a fourth byte is NACKed.
REQ-037 STOP injected during bit 3 of a read byte holding 0 -> sda_oe=0 within 3 cycles, FSM=IDLE; rstn pulse mid-write -> all outputs at reset values.

Source files
------------

// File: rtl/sht30_pkg.sv
// Shared definitions for the SHT30-style I2C target: FSM encoding, command and CRC constants.
package sht30_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StAddr,
    StAddrAck,
    StWrByte,
    StWrAck,
    StRdByte,
    StRdAck,
    StWaitStop
  } state_e;

  localparam logic [15:0] CmdMeasure = 16'h2C06;
  localparam logic [7:0]  CrcPoly    = 8'h31;
  localparam logic [7:0]  CrcInit    = 8'hFF;
  localparam int unsigned RdBytes    = 6;

endpackage

// File: rtl/crc8_sht30.sv
// Combinational CRC-8 (poly 0x31, init 0xFF, MSB first) over one 16-bit measurement word.
module crc8_sht30
  import sht30_pkg::*;
(
  input  logic [15:0] data_i,
  output logic [7:0]  crc_o
);

  logic [7:0] c;

  always_comb begin
    c = CrcInit;
    for (int i = 15; i >= 0; i--) begin
      if (c[7] ^ data_i[i]) c = {c[6:0], 1'b0} ^ CrcPoly;
      else                  c = {c[6:0], 1'b0};
    end
    crc_o = c;
  end

endmodule

// File: rtl/sht30_target.sv
// I2C target emulating an SHT30: accepts 2-byte commands, snapshots a measurement on 0x2C06
// and returns T, CRC(T), H, CRC(H) on read. Never stretches SCL.
module sht30_target
  import sht30_pkg::*;
#(
  parameter logic [6:0] ADDR7 = 7'h44
) (
  input  logic        clk_50M,
  input  logic        rstn,
  input  logic        scl_in,
  input  logic        sda_in,
  output logic        sda_oe,
  input  logic [15:0] temp_raw,
  input  logic [15:0] humi_raw,
  output logic        cmd_valid,
  output logic [15:0] cmd_word,
  output logic        busy
);

  logic [1:0]  scl_sync_q, sda_sync_q, arm_q, arm_d;
  logic        scl_prev_q, sda_prev_q;
  logic        scl_s, sda_s, armed;
  logic        scl_rise, scl_fall, start_det, stop_det;

  state_e      state_q, state_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shreg_q, shreg_d;
  logic [6:0]  tx_q, tx_d;
  logic [1:0]  wr_idx_q, wr_idx_d;
  logic [2:0]  rd_idx_q, rd_idx_d, rd_idx_inc, rd_sel;
  logic [7:0]  cmd_hi_q, cmd_hi_d, tx_byte, crc_t, crc_h;
  logic [15:0] cmd_word_q, cmd_word_d, snap_t_q, snap_t_d, snap_h_q, snap_h_d;
  logic        cmd_valid_q, cmd_valid_d, busy_q, busy_d, pending_q, pending_d, oe_q, oe_d;

  assign scl_s = scl_sync_q[1];
  assign sda_s = sda_sync_q[1];
  // Edge detection is held off until the synchroniser pipeline holds real bus levels.
  assign armed = &arm_q;
  assign arm_d = armed ? arm_q : arm_q + 2'd1;

  assign scl_rise  = armed & scl_s & ~scl_prev_q;
  assign scl_fall  = armed & ~scl_s & scl_prev_q;
  assign start_det = armed & scl_s & scl_prev_q & sda_prev_q & ~sda_s;
  assign stop_det  = armed & scl_s & scl_prev_q & ~sda_prev_q & sda_s;

  assign sda_oe    = oe_q & ~stop_det;
  assign cmd_valid = cmd_valid_q;
  assign cmd_word  = cmd_word_q;
  assign busy      = busy_q;

  crc8_sht30 u_crc_t (
    .data_i (snap_t_q),
    .crc_o  (crc_t)
  );

  crc8_sht30 u_crc_h (
    .data_i (snap_h_q),
    .crc_o  (crc_h)
  );

  always_comb begin
    rd_idx_inc = (rd_idx_q == 3'(RdBytes)) ? rd_idx_q : rd_idx_q + 3'd1;
    rd_sel     = (state_q == StRdAck) ? rd_idx_inc : 3'd0;
    case (rd_sel)
      3'd0:    tx_byte = snap_t_q[15:8];
      3'd1:    tx_byte = snap_t_q[7:0];
      3'd2:    tx_byte = crc_t;
      3'd3:    tx_byte = snap_h_q[15:8];
      3'd4:    tx_byte = snap_h_q[7:0];
      3'd5:    tx_byte = crc_h;
      default: tx_byte = 8'hFF;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shreg_d     = shreg_q;
    tx_d        = tx_q;
    oe_d        = oe_q;
    wr_idx_d    = wr_idx_q;
    rd_idx_d    = rd_idx_q;
    cmd_hi_d    = cmd_hi_q;
    cmd_word_d  = cmd_word_q;
    cmd_valid_d = 1'b0;
    busy_d      = busy_q;
    pending_d   = pending_q;
    snap_t_d    = snap_t_q;
    snap_h_d    = snap_h_q;

    if (stop_det) begin
      state_d = StIdle;
      oe_d    = 1'b0;
      busy_d  = 1'b0;
    end else if (start_det) begin
      state_d   = StAddr;
      oe_d      = 1'b0;
      bit_cnt_d = 4'd0;
      wr_idx_d  = 2'd0;
      rd_idx_d  = 3'd0;
    end else begin
      unique case (state_q)
        StAddr: begin
          if (scl_rise) begin
            shreg_d   = {shreg_q[6:0], sda_s};
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall && bit_cnt_q == 4'd8) begin
            if (shreg_q[7:1] != ADDR7) begin
              state_d = StWaitStop;
            end else begin
              busy_d = 1'b1;
              if (!shreg_q[0] || pending_q) begin
                state_d = StAddrAck;
                oe_d    = 1'b1;
                if (shreg_q[0]) pending_d = 1'b0;
              end else begin
                state_d = StWaitStop;
              end
            end
          end
        end
        StAddrAck: begin
          if (scl_fall) begin
            bit_cnt_d = 4'd0;
            if (shreg_q[0]) begin
              state_d  = StRdByte;
              rd_idx_d = 3'd0;
              oe_d     = ~tx_byte[7];
              tx_d     = tx_byte[6:0];
            end else begin
              state_d = StWrByte;
              oe_d    = 1'b0;
            end
          end
        end
        StWrByte: begin
          if (scl_rise) begin
            shreg_d   = {shreg_q[6:0], sda_s};
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall && bit_cnt_q == 4'd8) begin
            if (wr_idx_q < 2'd2) begin
              state_d = StWrAck;
              oe_d    = 1'b1;
            end else begin
              state_d = StWaitStop;
            end
          end
        end
        StWrAck: begin
          if (scl_fall) begin
            state_d   = StWrByte;
            oe_d      = 1'b0;
            bit_cnt_d = 4'd0;
            wr_idx_d  = wr_idx_q + 2'd1;
            if (wr_idx_q == 2'd0) begin
              cmd_hi_d = shreg_q;
            end else begin
              cmd_word_d  = {cmd_hi_q, shreg_q};
              cmd_valid_d = 1'b1;
              if ({cmd_hi_q, shreg_q} == CmdMeasure) begin
                snap_t_d  = temp_raw;
                snap_h_d  = humi_raw;
                pending_d = 1'b1;
              end
            end
          end
        end
        StRdByte: begin
          if (scl_rise) begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall) begin
            if (bit_cnt_q == 4'd8) begin
              state_d = StRdAck;
              oe_d    = 1'b0;
            end else begin
              oe_d = ~tx_q[6];
              tx_d = {tx_q[5:0], 1'b0};
            end
          end
        end
        StRdAck: begin
          // Master NACK ends the read; ACK loads the next byte at the following SCL fall.
          if (scl_rise && sda_s) begin
            state_d = StWaitStop;
          end else if (scl_fall) begin
            state_d   = StRdByte;
            bit_cnt_d = 4'd0;
            rd_idx_d  = rd_idx_inc;
            oe_d      = ~tx_byte[7];
            tx_d      = tx_byte[6:0];
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_50M or negedge rstn) begin
    if (!rstn) begin
      scl_sync_q  <= 2'b11;
      sda_sync_q  <= 2'b11;
      scl_prev_q  <= 1'b1;
      sda_prev_q  <= 1'b1;
      arm_q       <= 2'd0;
      state_q     <= StIdle;
      bit_cnt_q   <= 4'd0;
      shreg_q     <= 8'h00;
      tx_q        <= 7'h00;
      wr_idx_q    <= 2'd0;
      rd_idx_q    <= 3'd0;
      cmd_hi_q    <= 8'h00;
      cmd_word_q  <= 16'h0000;
      cmd_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      pending_q   <= 1'b0;
      snap_t_q    <= 16'h0000;
      snap_h_q    <= 16'h0000;
      oe_q        <= 1'b0;
    end else begin
      scl_sync_q  <= {scl_sync_q[0], scl_in};
      sda_sync_q  <= {sda_sync_q[0], sda_in};
      scl_prev_q  <= scl_s;
      sda_prev_q  <= sda_s;
      arm_q       <= arm_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shreg_q     <= shreg_d;
      tx_q        <= tx_d;
      wr_idx_q    <= wr_idx_d;
      rd_idx_q    <= rd_idx_d;
      cmd_hi_q    <= cmd_hi_d;
      cmd_word_q  <= cmd_word_d;
      cmd_valid_q <= cmd_valid_d;
      busy_q      <= busy_d;
      pending_q   <= pending_d;
      snap_t_q    <= snap_t_d;
      snap_h_q    <= snap_h_d;
      oe_q        <= oe_d;
    end
  end

endmodule

// File: tb/tb_sht30_target.sv
// Directed bench for sht30_target: a bit-banged I2C master plus a transaction-level sensor model.
module tb_sht30_target;
  import sht30_pkg::*;

  localparam int Q = 10;  // quarter SCL period in clk_50M cycles

  logic        clk_50M = 1'b0;
  logic        rstn;
  logic        scl_m, sda_m, inject, quiet, chk_on;
  logic        scl_in, sda_in, sda_oe, cmd_valid, busy;
  logic [15:0] temp_raw, humi_raw, cmd_word;

  assign scl_in = scl_m;
  assign sda_in = inject ? sda_m : (sda_m & ~sda_oe);

  always #10 clk_50M = ~clk_50M;

  sht30_target #(
    .ADDR7 (7'h44)
  ) dut (
    .clk_50M   (clk_50M),
    .rstn      (rstn),
    .scl_in    (scl_in),
    .sda_in    (sda_in),
    .sda_oe    (sda_oe),
    .temp_raw  (temp_raw),
    .humi_raw  (humi_raw),
    .cmd_valid (cmd_valid),
    .cmd_word  (cmd_word),
    .busy      (busy)
  );

  int n_chk = 0;
  int n_fail = 0;

  // Sensor model state
  logic        m_pending;
  logic [15:0] m_t, m_h;
  logic [7:0]  m_hi;
  logic [15:0] exp_cmd_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] crc_m(input logic [15:0] w);
    logic [7:0] c;
    c = 8'hFF;
    for (int b = 1; b >= 0; b--) begin
      c = c ^ w[8*b +: 8];
      for (int k = 0; k < 8; k++) c = c[7] ? ((c << 1) ^ 8'h31) : (c << 1);
    end
    return c;
  endfunction

  function automatic logic [7:0] exp_rd(input int idx);
    case (idx)
      0:       return m_t[15:8];
      1:       return m_t[7:0];
      2:       return crc_m(m_t);
      3:       return m_h[15:8];
      4:       return m_h[7:0];
      5:       return crc_m(m_h);
      default: return 8'hFF;
    endcase
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk_50M);
  endtask

  task automatic bus_start();
    sda_m = 1'b1; tick(Q);
    scl_m = 1'b1; tick(Q);
    sda_m = 1'b0; tick(Q);
    scl_m = 1'b0; tick(Q);
  endtask

  task automatic bus_stop();
    sda_m = 1'b0; tick(Q);
    scl_m = 1'b1; tick(Q);
    sda_m = 1'b1; tick(Q);
  endtask

  task automatic put_bit(input logic b);
    sda_m = b;    tick(Q);
    scl_m = 1'b1; tick(2 * Q);
    scl_m = 1'b0; tick(Q);
  endtask

  task automatic get_bit(output logic b);
    sda_m = 1'b1; tick(Q);
    scl_m = 1'b1; tick(Q);
    b = sda_in;   tick(Q);
    scl_m = 1'b0; tick(Q);
  endtask

  task automatic put_byte(input logic [7:0] d, output logic ack);
    logic nak;
    for (int i = 7; i >= 0; i--) put_bit(d[i]);
    get_bit(nak);
    ack = ~nak;
  endtask

  task automatic get_byte(output logic [7:0] d, input logic ack);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      get_bit(b);
      d[i] = b;
    end
    put_bit(~ack);
  endtask

  task automatic m_addr(input logic [7:0] a);
    logic ack, match, exp;
    match = (a[7:1] == 7'h44);
    exp   = match && (!a[0] || m_pending);
    put_byte(a, ack);
    check($sformatf("addr %0h ack", a), 32'(ack), 32'(exp));
    check($sformatf("addr %0h busy", a), 32'(busy), 32'(match));
    if (exp && a[0]) m_pending = 1'b0;
  endtask

  task automatic m_wbyte(input logic [7:0] d, input int idx);
    logic ack;
    logic [15:0] cmd;
    cmd = {m_hi, d};
    if (idx == 1) exp_cmd_q.push_back(cmd);
    put_byte(d, ack);
    check($sformatf("write byte %0d ack", idx), 32'(ack), 32'(idx < 2));
    if (idx == 0) m_hi = d;
    if (idx == 1 && cmd == 16'h2C06) begin
      m_t       = temp_raw;
      m_h       = humi_raw;
      m_pending = 1'b1;
    end
  endtask

  task automatic m_rbyte(input int idx, input logic ack, output logic [7:0] d);
    logic [7:0] e;
    e = exp_rd(idx);
    get_byte(d, ack);
    check($sformatf("read byte %0d", idx), 32'(d), 32'(e));
  endtask

  // Continuous checks on outputs that must hold on every cycle
  logic oe_prev = 1'b0;
  logic cv_prev = 1'b0;
  always @(negedge clk_50M) begin
    if (chk_on) begin
      if (cmd_valid) begin
        if (exp_cmd_q.size() == 0) check("cmd_valid unexpected", 32'(cmd_valid), 32'd0);
        else check("cmd_word at pulse", 32'(cmd_word), 32'(exp_cmd_q.pop_front()));
        check("cmd_valid one cycle", 32'(cv_prev), 32'd0);
      end
      if (quiet) check("sda_oe released", 32'(sda_oe), 32'd0);
      if (!inject && scl_m && sda_oe != oe_prev)
        check("sda_oe changed with SCL high", 32'(sda_oe), 32'(oe_prev));
    end
    oe_prev <= sda_oe;
    cv_prev <= cmd_valid;
  end

  initial begin
    logic [7:0] got[6];
    logic [7:0] lit[6];
    logic       b;
    logic       ack;
    lit = '{8'hBE, 8'hEF, 8'h92, 8'h80, 8'h00, 8'hA2};

    rstn = 1'b0; scl_m = 1'b1; sda_m = 1'b1; inject = 1'b0; quiet = 1'b0; chk_on = 1'b0;
    temp_raw = 16'hBEEF; humi_raw = 16'h8000;
    m_pending = 1'b0; m_t = '0; m_h = '0; m_hi = '0;
    tick(3);
    check("reset sda_oe", 32'(sda_oe), 32'd0);
    check("reset cmd_valid", 32'(cmd_valid), 32'd0);
    check("reset cmd_word", 32'(cmd_word), 32'h0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset state", 32'(dut.state_q), 32'(StIdle));
    check("reset pending", 32'(dut.pending_q), 32'd0);
    rstn = 1'b1; chk_on = 1'b1; tick(5);

    // Measurement command, then repeated START and full read
    bus_start(); m_addr(8'h88); m_wbyte(8'h2C, 0); m_wbyte(8'h06, 1);
    check("pending after 2C06", 32'(dut.pending_q), 32'(m_pending));
    temp_raw = 16'h1111; humi_raw = 16'h2222;
    bus_start(); m_addr(8'h89);
    for (int i = 0; i < 6; i++) m_rbyte(i, i < 5, got[i]);
    for (int i = 0; i < 6; i++) check($sformatf("read literal %0d", i), 32'(got[i]), 32'(lit[i]));
    check("state after read NACK", 32'(dut.state_q), 32'(StWaitStop));
    check("pending after read", 32'(dut.pending_q), 32'(m_pending));
    bus_stop();
    check("busy after STOP", 32'(busy), 32'd0);
    check("state after STOP", 32'(dut.state_q), 32'(StIdle));

    // Foreign address
    quiet = 1'b1;
    bus_start(); m_addr(8'h90); put_byte(8'h55, ack);
    check("foreign data byte ack", 32'(ack), 32'd0);
    bus_stop();
    check("state after foreign", 32'(dut.state_q), 32'(StIdle));

    // Read with nothing pending
    bus_start(); m_addr(8'h89); get_byte(got[0], 1'b0);
    check("no data driven", 32'(got[0]), 32'hFF);
    bus_stop();
    quiet = 1'b0;

    // Non-measurement command plus an extra byte
    bus_start(); m_addr(8'h88); m_wbyte(8'h30, 0); m_wbyte(8'hA2, 1); m_wbyte(8'h55, 2);
    check("no snapshot on 30A2", 32'(dut.pending_q), 32'(m_pending));
    bus_stop();

    // STOP injected during bit 3 of a zero byte
    temp_raw = 16'h0012; humi_raw = 16'h3456;
    bus_start(); m_addr(8'h88); m_wbyte(8'h2C, 0); m_wbyte(8'h06, 1); bus_stop();
    bus_start(); m_addr(8'h89);
    get_bit(b); check("zero byte bit 7", 32'(b), 32'd0);
    get_bit(b); check("zero byte bit 6", 32'(b), 32'd0);
    sda_m = 1'b1; tick(Q);
    scl_m = 1'b1; tick(Q);
    check("zero byte bit 5 driven", 32'(sda_in), 32'd0);
    inject = 1'b1; sda_m = 1'b0; tick(2);
    sda_m = 1'b1; tick(3);
    check("sda_oe after injected STOP", 32'(sda_oe), 32'd0);
    check("state after injected STOP", 32'(dut.state_q), 32'(StIdle));
    tick(Q); inject = 1'b0; tick(Q);

    // Reset pulse in the middle of a write byte
    bus_start(); m_addr(8'h88);
    put_bit(1'b0); put_bit(1'b0); put_bit(1'b1); put_bit(1'b0);
    rstn = 1'b0; tick(1);
    check("mid reset sda_oe", 32'(sda_oe), 32'd0);
    check("mid reset cmd_valid", 32'(cmd_valid), 32'd0);
    check("mid reset cmd_word", 32'(cmd_word), 32'h0);
    check("mid reset busy", 32'(busy), 32'd0);
    check("mid reset state", 32'(dut.state_q), 32'(StIdle));
    check("mid reset pending", 32'(dut.pending_q), 32'd0);
    m_pending = 1'b0; m_t = '0; m_h = '0;
    tick(2); rstn = 1'b1; quiet = 1'b1;
    put_bit(1'b1); put_bit(1'b1); put_bit(1'b0); put_bit(1'b0);
    get_bit(b); check("ignored after reset", 32'(b), 32'd1);
    bus_stop(); quiet = 1'b0;
    check("state after reset recovery", 32'(dut.state_q), 32'(StIdle));
    bus_start(); m_addr(8'h88); bus_stop();

    tick(Q);
    check("all cmd pulses seen", 32'(exp_cmd_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
